// File: rtl/otp_ctrl_key_bcast.sv
// Round-robin ephemeral key broadcast: gathers EDN words per grant, mixes the key with the OTP seed.
// Optional EDN repetition/stuck-word filter is compiled in when OTP_KEY_BCAST_REPCHK_EN is defined.
module otp_ctrl_key_bcast #(
  parameter int NumReq     = 4,
  parameter int KeyWidth   = 128,
  parameter int NonceWidth = 64,
  parameter int EdnWidth   = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumReq-1:0]     req_i,
  output logic [NumReq-1:0]     ack_o,
  output logic [KeyWidth-1:0]   key_o,
  output logic [NonceWidth-1:0] nonce_o,
  output logic                  seed_valid_o,
  input  logic [KeyWidth-1:0]   key_seed_i,
  input  logic                  seed_valid_i,
  output logic                  edn_req_o,
  input  logic                  edn_ack_i,
  input  logic [EdnWidth-1:0]   edn_data_i,
  output logic                  busy_o,
  output logic                  err_o
);
  localparam int NumEdnWords = (KeyWidth + NonceWidth + EdnWidth - 1) / EdnWidth;
  localparam int BufWidth    = NumEdnWords * EdnWidth;
  localparam int IdxW        = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW        = $clog2(NumEdnWords + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_ACK} state_e;

  state_e                state_reg;
  logic [IdxW-1:0]       ptr_reg;
  logic [IdxW-1:0]       grant_reg;
  logic [CntW-1:0]       cnt_reg;
  logic                  seed_latch_reg;
  logic [NumReq-1:0]     ack_reg;
  logic [KeyWidth-1:0]   key_reg;
  logic [NonceWidth-1:0] nonce_reg;
  logic                  seed_valid_reg;
  logic [BufWidth-1:0]   buf_flat;

  logic [IdxW-1:0]       cand_idx [NumReq];
  logic [NumReq-1:0]     cand_req;
  logic [IdxW-1:0]       gnt_next;
  logic                  gnt_valid;
  logic                  word_ok;
  logic                  edn_take;

  genvar gi;

  // Candidate gi is the channel gi places after the pointer, wrapping at NumReq.
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_cand
      logic [IdxW:0] sum;
      assign sum          = {1'b0, ptr_reg} + (IdxW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IdxW+1)'(NumReq)) ? IdxW'(sum - (IdxW+1)'(NumReq))
                                                        : sum[IdxW-1:0];
      assign cand_req[gi] = req_i[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    gnt_next  = ptr_reg;
    gnt_valid = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        gnt_next  = cand_idx[i];
        gnt_valid = 1'b1;
      end
    end
  end

`ifdef OTP_KEY_BCAST_REPCHK_EN
  logic [EdnWidth-1:0] prev_word_reg;
  logic                err_reg;
  logic                word_bad;

  // Stuck-at words and repeats of the last accepted word are dropped; the fetch simply continues.
  assign word_bad = (edn_data_i == '0) || (&edn_data_i) ||
                    ((cnt_reg != '0) && (edn_data_i == prev_word_reg));
  assign word_ok  = ~word_bad;
  assign err_o    = err_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_word_reg <= '0;
      err_reg       <= 1'b0;
    end else if ((state_reg == ST_FETCH) && edn_ack_i) begin
      if (word_bad) begin
        err_reg <= 1'b1;
      end else begin
        prev_word_reg <= edn_data_i;
      end
    end
  end
`else
  assign word_ok = 1'b1;
  assign err_o   = 1'b0;
`endif

  assign edn_take = (state_reg == ST_FETCH) && edn_ack_i && word_ok;

  generate
    for (gi = 0; gi < NumEdnWords; gi++) begin : g_buf
      logic [EdnWidth-1:0] word_reg;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          word_reg <= '0;
        end else if (edn_take && (cnt_reg == CntW'(gi))) begin
          word_reg <= edn_data_i;
        end
      end
      assign buf_flat[gi*EdnWidth +: EdnWidth] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= '0;
      grant_reg      <= '0;
      cnt_reg        <= '0;
      seed_latch_reg <= 1'b0;
      ack_reg        <= '0;
      key_reg        <= '0;
      nonce_reg      <= '0;
      seed_valid_reg <= 1'b0;
    end else begin
      ack_reg <= '0;
      unique case (state_reg)
        ST_IDLE: begin
          if (gnt_valid) begin
            grant_reg      <= gnt_next;
            seed_latch_reg <= seed_valid_i;
            cnt_reg        <= '0;
            state_reg      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (edn_take) begin
            cnt_reg <= cnt_reg + CntW'(1);
            if (cnt_reg == CntW'(NumEdnWords - 1)) begin
              state_reg <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          // An abandoned request still advances the pointer so it cannot starve others.
          if (req_i[grant_reg]) begin
            ack_reg        <= NumReq'(1) << grant_reg;
            key_reg        <= buf_flat[KeyWidth-1:0] ^ key_seed_i;
            nonce_reg      <= buf_flat[KeyWidth +: NonceWidth];
            seed_valid_reg <= seed_latch_reg;
          end
          ptr_reg   <= (grant_reg == IdxW'(NumReq - 1)) ? '0 : grant_reg + IdxW'(1);
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ack_o        = ack_reg;
  assign key_o        = key_reg;
  assign nonce_o      = nonce_reg;
  assign seed_valid_o = seed_valid_reg;
  assign busy_o       = (state_reg != ST_IDLE);
  assign edn_req_o    = (state_reg == ST_FETCH);

endmodule

// File: tb/tb_otp_ctrl_key_bcast.sv
// Directed self-checking bench for otp_ctrl_key_bcast with a negedge-driven EDN responder.
module tb_otp_ctrl_key_bcast;
  localparam int NumReq     = 4;
  localparam int KeyWidth   = 128;
  localparam int NonceWidth = 64;
  localparam int EdnWidth   = 64;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic [NumReq-1:0]     req_i;
  logic [NumReq-1:0]     ack_o;
  logic [KeyWidth-1:0]   key_o;
  logic [NonceWidth-1:0] nonce_o;
  logic                  seed_valid_o;
  logic [KeyWidth-1:0]   key_seed_i;
  logic                  seed_valid_i;
  logic                  edn_req_o;
  logic                  edn_ack_i = 1'b0;
  logic [EdnWidth-1:0]   edn_data_i = '0;
  logic                  busy_o;
  logic                  err_o;

  always #5 clk = ~clk;

  otp_ctrl_key_bcast #(
    .NumReq(NumReq), .KeyWidth(KeyWidth), .NonceWidth(NonceWidth), .EdnWidth(EdnWidth)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .ack_o(ack_o), .key_o(key_o),
    .nonce_o(nonce_o), .seed_valid_o(seed_valid_o), .key_seed_i(key_seed_i),
    .seed_valid_i(seed_valid_i), .edn_req_o(edn_req_o), .edn_ack_i(edn_ack_i),
    .edn_data_i(edn_data_i), .busy_o(busy_o), .err_o(err_o)
  );

  // EDN responder: offers the next queued word whenever the DUT requests entropy.
  logic [EdnWidth-1:0] edn_words [64];
  int edn_idx = 0;
  int edn_lim = 0;
  always @(negedge clk) begin
    if (edn_req_o && (edn_idx < edn_lim)) begin
      edn_ack_i  = 1'b1;
      edn_data_i = edn_words[edn_idx % 64];
      edn_idx++;
    end else begin
      edn_ack_i = 1'b0;
    end
  end

  logic multi_hot = 1'b0;
  always @(negedge clk) begin
    if (!$onehot0(ack_o)) multi_hot = 1'b1;
  end

  int n_vec  = 0;
  int n_miss = 0;
  int cyc;
  int base;
  int n;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [EdnWidth-1:0] w);
    edn_words[edn_lim % 64] = w;
    edn_lim++;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while ((ack_o == '0) && (lat < 40));
    chk("ack_seen", {191'b0, |ack_o}, 192'd1);
    $display("txn ack=%b key=%h nonce=%h sv=%b lat=%0d", ack_o, key_o, nonce_o, seed_valid_o, lat);
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  logic [63:0] w1, w2, w3, w4, w5, w6, w7, w8, w9, wa, wb, wc;
  logic [127:0] k2;
  logic [3:0] exp_ack;
  logic [3:0] dropped;

  initial begin
    w1 = {16{4'h1}}; w2 = {16{4'h2}}; w3 = {16{4'h3}};
    w4 = {16{4'h4}}; w5 = {16{4'h5}}; w6 = {16{4'h6}};
    w7 = {16{4'h7}}; w8 = {16{4'h8}}; w9 = {16{4'h9}};
    wa = 64'h0123_4567_89AB_CDEF; wb = 64'hFEDC_BA98_7654_3210; wc = 64'h0F0F_0F0F_F0F0_F0F0;
    k2 = {{16{4'hD}}, {16{4'hE}}};

    rst_i = 1'b1; req_i = '0; key_seed_i = '0; seed_valid_i = 1'b0;
    repeat (3) step();
    chk("rst_ack", ack_o, 0);
    chk("rst_key", key_o, 0);
    chk("rst_nonce", nonce_o, 0);
    chk("rst_sv", seed_valid_o, 0);
    chk("rst_ednreq", edn_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;

    // Basic transaction on channel 1, zero seed
    base = edn_idx;
    push(w1); push(w2); push(w3);
    req_i = 4'b0010;
    wait_ack(cyc);
    chk("t1_latency", cyc, 5);
    chk("t1_ack", ack_o, 4'b0010);
    chk("t1_key", key_o, {w2, w1});
    chk("t1_nonce", nonce_o, w3);
    chk("t1_sv", seed_valid_o, 0);
    req_i = '0;
    step();

    // All-ones seed; seed_valid is captured at grant, not at ack
    push(w1); push(w2); push(w3);
    key_seed_i = '1; seed_valid_i = 1'b1;
    req_i = 4'b0010;
    step();
    seed_valid_i = 1'b0;
    wait_ack(cyc);
    chk("t2_ack", ack_o, 4'b0010);
    chk("t2_key", key_o, k2);
    chk("t2_nonce", nonce_o, w3);
    chk("t2_sv", seed_valid_o, 1);
    req_i = '0;
    step();

    // Channel 2 abandons mid-fetch while channel 0 starts requesting
    key_seed_i = '0;
    base = edn_idx;
    push(64'hAAAA_0000_AAAA_0001); push(64'hBBBB_0000_BBBB_0002); push(64'hCCCC_0000_CCCC_0003);
    push(w4); push(w5); push(w6);
    req_i = 4'b0100;
    step();
    step();
    req_i = 4'b0001;
    n = 0;
    do begin
      step();
      n++;
    end while (busy_o && (n < 20));
    chk("t4_idle", busy_o, 0);
    chk("t4_noack", ack_o, 0);
    chk("t4_key_hold", key_o, k2);
    chk("t4_nonce_hold", nonce_o, w3);
    wait_ack(cyc);
    chk("t4_next_ack", ack_o, 4'b0001);
    chk("t4_next_key", key_o, {w5, w4});
    chk("t4_next_nonce", nonce_o, w6);
    chk("t4_words", edn_idx - base, 6);
    req_i = '0;
    step();

    // Round-robin fairness with every channel requesting
    apply_reset();
    for (int k = 1; k <= 15; k++) push(64'h1000_0000_0000_0000 + 64'(k));
    req_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack(cyc);
      exp_ack = 4'b0001 << (k % 4);
      chk($sformatf("rr_grant%0d", k), ack_o, exp_ack);
      dropped = ack_o;
      req_i = req_i & ~dropped;
      step();
      req_i = req_i | dropped;
    end
    req_i = '0;
    chk("rr_onehot0", multi_hot, 0);

    // Repetition filter: A, A, B, C
    apply_reset();
    edn_lim = edn_idx;
    base = edn_idx;
    push(wa); push(wa); push(wb); push(wc);
    req_i = 4'b0001;
    wait_ack(cyc);
`ifdef OTP_KEY_BCAST_REPCHK_EN
    chk("rep_words", edn_idx - base, 4);
    chk("rep_key", key_o, {wb, wa});
    chk("rep_nonce", nonce_o, wc);
    chk("rep_err", err_o, 1);
`else
    chk("rep_words", edn_idx - base, 3);
    chk("rep_key", key_o, {wa, wa});
    chk("rep_nonce", nonce_o, wb);
    chk("rep_err", err_o, 0);
`endif
    req_i = '0;
    step();

    // Reset after the first EDN word aborts the fetch
    edn_lim = edn_idx;
    base = edn_idx;
    push(w7); push(w8); push(w9);
    req_i = 4'b0001;
    n = 0;
    do begin
      step();
      n++;
    end while (((edn_idx - base) < 1) && (n < 20));
    chk("t5_first_word", edn_idx - base, 1);
    step();
    rst_i = 1'b1;
    step();
    chk("t5_ednreq", edn_req_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_key", key_o, 0);
    chk("t5_nonce", nonce_o, 0);
    chk("t5_ack", ack_o, 0);
    chk("t5_err", err_o, 0);
    rst_i = 1'b0;
    edn_lim = edn_idx;
    base = edn_idx;
    push(w7); push(w8); push(w9);
    wait_ack(cyc);
    chk("t5_refetch", edn_idx - base, 3);
    chk("t5_re_ack", ack_o, 4'b0001);
    chk("t5_re_key", key_o, {w8, w7});
    chk("t5_re_nonce", nonce_o, w9);
    req_i = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
